// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back arbiter: the queued-write entry,
// the forward result and the youngest-match fold used by the rd CAM.
package wb_pkg;

    localparam int WB_AW = 5;
    localparam int WB_DW = 32;
    localparam logic [WB_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic             live;
        logic             kill;
        logic [WB_AW-1:0] rd;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

    typedef struct packed {
        logic             hit;
        logic [WB_DW-1:0] data;
    } wb_fwd_t;

    // Fold step: callers walk entries oldest to youngest, so the last hit wins.
    function automatic wb_fwd_t youngest_match(wb_fwd_t older, wb_entry_t e, logic [WB_AW-1:0] rs);
        wb_fwd_t r;
        r = older;
        if (e.live && !e.kill && (rs != REG_ZERO) && (e.rd == rs)) begin
            r.hit  = 1'b1;
            r.data = e.data;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending ALU writes with kill-by-rd and a two-port rd CAM
// returning the youngest live value for each decode read address.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WB_AW-1:0]         push_rd_i,
    input  logic [WB_DW-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     kill_i,
    input  logic [WB_AW-1:0]         kill_rd_i,
    input  logic [WB_AW-1:0]         rs1_i,
    input  logic [WB_AW-1:0]         rs2_i,
    output wb_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output wb_fwd_t                  fwd1_o,
    output wb_fwd_t                  fwd2_o
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW:0]     count_q;

    // Kill is applied before the push so an entry written this edge is never killed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_i && mem_q[i].live && (mem_q[i].rd == kill_rd_i)) mem_q[i].kill <= 1'b1;
            end
            if (pop_i) begin
                mem_q[rd_ptr_q].live <= 1'b0;
                rd_ptr_q             <= rd_ptr_q + 1'b1;
            end
            if (push_i) begin
                mem_q[wr_ptr_q] <= '{live: 1'b1, kill: 1'b0, rd: push_rd_i, data: push_data_i};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        logic [PW-1:0] idx;
        idx    = '0;
        fwd1_o = '0;
        fwd2_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx    = rd_ptr_q + i[PW-1:0];
            fwd1_o = youngest_match(fwd1_o, mem_q[idx], rs1_i);
            fwd2_o = youngest_match(fwd2_o, mem_q[idx], rs2_i);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file write port: loads first, then queued ALU
// results, then an ALU bypass. Define WB_FWD_EN to turn hazards into forwards.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   AluValid,
    input  logic [AW-1:0]          AluRd,
    input  logic [DW-1:0]          AluData,
    output logic                   AluReady,
    input  logic                   MemValid,
    input  logic [AW-1:0]          MemRd,
    input  logic [DW-1:0]          MemData,
    input  logic [AW-1:0]          RS1,
    input  logic [AW-1:0]          RS2,
    output logic                   Hazard1,
    output logic                   Hazard2,
    output logic                   Fwd1Valid,
    output logic                   Fwd2Valid,
    output logic [DW-1:0]          Fwd1Data,
    output logic [DW-1:0]          Fwd2Data,
    output logic [AW-1:0]          RD,
    output logic [DW-1:0]          WData,
    output logic                   RegWr,
    output logic [$clog2(DEPTH):0] Occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
`ifdef WB_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic [AW-1:0] RD_q, RD_d;
    logic [DW-1:0] WData_q, WData_d;
    logic          RegWr_q, RegWr_d;

    wb_entry_t     fifo_head;
    wb_fwd_t       fifo_fwd1, fifo_fwd2;
    wb_entry_t     out_e;
    wb_fwd_t       m1, m2;
    logic [CW-1:0] occ;
    logic          mem_win, alu_acc, alu_wr, bypass, fifo_push, fifo_pop;

    // ALU handshake: a result transfers on an edge where AluValid && AluReady; the
    // producer holds AluRd/AluData stable until then. Loads have no handshake.
    assign AluReady  = Reset_n && (occ < FULL);
    assign mem_win   = MemValid && (MemRd != REG_ZERO);
    assign alu_acc   = AluValid && AluReady;
    assign alu_wr    = alu_acc && (AluRd != REG_ZERO);
    assign fifo_pop  = !mem_win && fifo_head.live;
    assign bypass    = !mem_win && !fifo_head.live && alu_wr;
    assign fifo_push = alu_wr && !bypass;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (Clk),
        .rst_ni      (Reset_n),
        .push_i      (fifo_push),
        .push_rd_i   (AluRd),
        .push_data_i (AluData),
        .pop_i       (fifo_pop),
        .kill_i      (mem_win),
        .kill_rd_i   (MemRd),
        .rs1_i       (RS1),
        .rs2_i       (RS2),
        .head_o      (fifo_head),
        .count_o     (occ),
        .fwd1_o      (fifo_fwd1),
        .fwd2_o      (fifo_fwd2)
    );

    always_comb begin
        RD_d    = '0;
        WData_d = '0;
        RegWr_d = 1'b0;
        if (mem_win) begin
            RD_d    = MemRd;
            WData_d = MemData;
            RegWr_d = 1'b1;
        end else if (fifo_head.live) begin
            if (!fifo_head.kill) begin
                RD_d    = fifo_head.rd;
                WData_d = fifo_head.data;
                RegWr_d = 1'b1;
            end
        end else if (alu_wr) begin
            RD_d    = AluRd;
            WData_d = AluData;
            RegWr_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            RD_q    <= '0;
            WData_q <= '0;
            RegWr_q <= 1'b0;
        end else begin
            RD_q    <= RD_d;
            WData_q <= WData_d;
            RegWr_q <= RegWr_d;
        end
    end

    // The output register is the oldest pending write; any FIFO hit is younger.
    assign out_e = '{live: RegWr_q, kill: 1'b0, rd: RD_q, data: WData_q};

    always_comb begin
        m1 = youngest_match('0, out_e, RS1);
        m2 = youngest_match('0, out_e, RS2);
        if (fifo_fwd1.hit) m1 = fifo_fwd1;
        if (fifo_fwd2.hit) m2 = fifo_fwd2;
    end

    assign Hazard1   = m1.hit && !FWD_EN;
    assign Hazard2   = m2.hit && !FWD_EN;
    assign Fwd1Valid = m1.hit && FWD_EN;
    assign Fwd2Valid = m2.hit && FWD_EN;
    assign Fwd1Data  = FWD_EN ? m1.data : '0;
    assign Fwd2Data  = FWD_EN ? m2.data : '0;

    assign RD        = RD_q;
    assign WData     = WData_q;
    assign RegWr     = RegWr_q;
    assign Occupancy = occ;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: scenario tasks plus an in-order
// scoreboard of expected register-file writes.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = 3;

    logic          Clk, Reset_n;
    logic          AluValid, MemValid;
    logic [AW-1:0] AluRd, MemRd, RS1, RS2, RD;
    logic [DW-1:0] AluData, MemData, WData, Fwd1Data, Fwd2Data;
    logic          AluReady, Hazard1, Hazard2, Fwd1Valid, Fwd2Valid, RegWr;
    logic [CW-1:0] Occupancy;

    int checks   = 0;
    int failures = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_exp;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .AluValid  (AluValid),
        .AluRd     (AluRd),
        .AluData   (AluData),
        .AluReady  (AluReady),
        .MemValid  (MemValid),
        .MemRd     (MemRd),
        .MemData   (MemData),
        .RS1       (RS1),
        .RS2       (RS2),
        .Hazard1   (Hazard1),
        .Hazard2   (Hazard2),
        .Fwd1Valid (Fwd1Valid),
        .Fwd2Valid (Fwd2Valid),
        .Fwd1Data  (Fwd1Data),
        .Fwd2Data  (Fwd2Data),
        .RD        (RD),
        .WData     (WData),
        .RegWr     (RegWr),
        .Occupancy (Occupancy)
    );

    // Clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every register-file write must match the oldest expectation.
    always @(negedge Clk) begin
        if (Reset_n && RegWr === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h, required no write", RD, WData);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({RD, WData} !== mon_exp) begin
                    failures++;
                    $display("FAIL wb_write: got rd=%0d data=%h, required rd=%0d data=%h",
                             RD, WData, mon_exp[AW+DW-1:DW], mon_exp[DW-1:0]);
                end
            end
        end
    end

    // Driver tasks
    task automatic idle_inputs();
        AluValid = 1'b0; AluRd = '0; AluData = '0;
        MemValid = 1'b0; MemRd = '0; MemData = '0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && Occupancy != 0; n++) @(negedge Clk);
        checks++;
        if (Occupancy !== '0) begin
            failures++;
            $display("FAIL drain_timeout: got occupancy=%0d, required 0", Occupancy);
        end
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        idle_inputs();
        RS1 = '0; RS2 = '0;
        @(negedge Clk); @(negedge Clk);
        checks++;
        if ({RegWr, RD, WData, Occupancy, AluReady} !== '0) begin
            failures++;
            $display("FAIL reset_state: got regwr=%b rd=%0d wdata=%h occ=%0d ready=%b, required all 0",
                     RegWr, RD, WData, Occupancy, AluReady);
        end
        Reset_n = 1'b1;
        #1;
        checks++;
        if (AluReady !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b, required 1", AluReady);
        end
    endtask

    task automatic test_alu_bypass();
        @(negedge Clk);
        AluValid = 1'b1; AluRd = 5'd3; AluData = 32'h11;
        exp_q.push_back({5'd3, 32'h11});
        @(negedge Clk);
        idle_inputs();
        checks++;
        if ({RD, WData, RegWr} !== {5'd3, 32'h11, 1'b1} || Occupancy !== 3'd0) begin
            failures++;
            $display("FAIL alu_bypass: got rd=%0d data=%h regwr=%b occ=%0d, required rd=3 data=11 regwr=1 occ=0",
                     RD, WData, RegWr, Occupancy);
        end
        @(negedge Clk);
    endtask

    task automatic test_mem_priority();
        @(negedge Clk);
        MemValid = 1'b1; MemRd = 5'd5; MemData = 32'h55;
        AluValid = 1'b1; AluRd = 5'd6; AluData = 32'h66;
        exp_q.push_back({5'd5, 32'h55});
        exp_q.push_back({5'd6, 32'h66});
        @(negedge Clk);
        idle_inputs();
        checks++;
        if (RD !== 5'd5 || RegWr !== 1'b1 || Occupancy !== 3'd1) begin
            failures++;
            $display("FAIL mem_first: got rd=%0d regwr=%b occ=%0d, required rd=5 regwr=1 occ=1", RD, RegWr, Occupancy);
        end
        @(negedge Clk);
        checks++;
        if (RD !== 5'd6 || WData !== 32'h66 || Occupancy !== 3'd0) begin
            failures++;
            $display("FAIL alu_second: got rd=%0d data=%h occ=%0d, required rd=6 data=66 occ=0", RD, WData, Occupancy);
        end
    endtask

    task automatic test_fill_backpressure();
        logic [AW+DW-1:0] alu_exp[$];
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge Clk);
            MemValid = 1'b1; MemRd = 5'(10 + k); MemData = $urandom;
            AluValid = 1'b1; AluRd = 5'(20 + k); AluData = $urandom;
            exp_q.push_back({MemRd, MemData});
            alu_exp.push_back({AluRd, AluData});
        end
        @(negedge Clk);
        checks++;
        if (Occupancy !== 3'd4 || AluReady !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: got occ=%0d ready=%b, required occ=4 ready=0", Occupancy, AluReady);
        end
        while (alu_exp.size() != 0) exp_q.push_back(alu_exp.pop_front());
        MemValid = 1'b0;
        AluRd = 5'd24; AluData = $urandom;
        #1;
        checks++;
        if (AluReady !== 1'b0) begin
            failures++;
            $display("FAIL no_pass_through: got ready=%b, required 0", AluReady);
        end
        @(negedge Clk);
        checks++;
        if (Occupancy !== 3'd3 || AluReady !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_pop: got occ=%0d ready=%b, required occ=3 ready=1", Occupancy, AluReady);
        end
        exp_q.push_back({AluRd, AluData});
        @(negedge Clk);
        idle_inputs();
        checks++;
        if (Occupancy !== 3'd3) begin
            failures++;
            $display("FAIL push_pop_occ: got %0d, required 3", Occupancy);
        end
        drain();
    endtask

    task automatic test_kill();
        @(negedge Clk);
        MemValid = 1'b1; MemRd = 5'd1; MemData = 32'h01;
        AluValid = 1'b1; AluRd = 5'd7; AluData = 32'hAA;
        exp_q.push_back({5'd1, 32'h01});
        @(negedge Clk);
        AluValid = 1'b0;
        MemRd = 5'd7; MemData = 32'hBB;
        exp_q.push_back({5'd7, 32'hBB});
        checks++;
        if (Occupancy !== 3'd1) begin
            failures++;
            $display("FAIL kill_queued: got occ=%0d, required 1", Occupancy);
        end
        @(negedge Clk);
        idle_inputs();
        checks++;
        if (RD !== 5'd7 || WData !== 32'hBB || RegWr !== 1'b1 || Occupancy !== 3'd1) begin
            failures++;
            $display("FAIL kill_load: got rd=%0d data=%h regwr=%b occ=%0d, required rd=7 data=bb regwr=1 occ=1",
                     RD, WData, RegWr, Occupancy);
        end
        @(negedge Clk);
        checks++;
        if (RegWr !== 1'b0 || Occupancy !== 3'd0) begin
            failures++;
            $display("FAIL killed_pop: got regwr=%b occ=%0d, required regwr=0 occ=0", RegWr, Occupancy);
        end
    endtask

    task automatic test_zero_and_hazard();
        @(negedge Clk);
        AluValid = 1'b1; AluRd = '0; AluData = 32'hDEAD;
        MemValid = 1'b1; MemRd = '0; MemData = 32'hBEEF;
        @(negedge Clk);
        idle_inputs();
        checks++;
        if (RegWr !== 1'b0 || Occupancy !== 3'd0) begin
            failures++;
            $display("FAIL rd_zero: got regwr=%b occ=%0d, required regwr=0 occ=0", RegWr, Occupancy);
        end
        MemValid = 1'b1; MemRd = 5'd2; MemData = 32'h22;
        AluValid = 1'b1; AluRd = 5'd9; AluData = 32'h99;
        exp_q.push_back({5'd2, 32'h22});
        exp_q.push_back({5'd9, 32'h99});
        @(negedge Clk);
        idle_inputs();
        RS1 = 5'd9; RS2 = 5'd2;
        #1;
        checks++;
`ifdef WB_FWD_EN
        if ({Fwd1Valid, Fwd2Valid, Hazard1, Hazard2} !== 4'b1100 || Fwd1Data !== 32'h99 || Fwd2Data !== 32'h22) begin
            failures++;
            $display("FAIL hazard_match: got fv=%b%b hz=%b%b d1=%h d2=%h, required fv=11 hz=00 d1=99 d2=22",
                     Fwd1Valid, Fwd2Valid, Hazard1, Hazard2, Fwd1Data, Fwd2Data);
        end
`else
        if ({Hazard1, Hazard2, Fwd1Valid, Fwd2Valid} !== 4'b1100 || Fwd1Data !== '0 || Fwd2Data !== '0) begin
            failures++;
            $display("FAIL hazard_match: got hz=%b%b fv=%b%b d1=%h d2=%h, required hz=11 fv=00 d=0",
                     Hazard1, Hazard2, Fwd1Valid, Fwd2Valid, Fwd1Data, Fwd2Data);
        end
`endif
        RS1 = 5'd4; RS2 = 5'd0;
        #1;
        checks++;
        if ({Hazard1, Hazard2, Fwd1Valid, Fwd2Valid} !== 4'b0000) begin
            failures++;
            $display("FAIL hazard_miss: got hz=%b%b fv=%b%b, required all 0", Hazard1, Hazard2, Fwd1Valid, Fwd2Valid);
        end
        @(negedge Clk);
        RS1 = '0;
        drain();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            MemValid = 1'b1; MemRd = 5'(14 + k); MemData = $urandom;
            AluValid = 1'b1; AluRd = 5'(25 + k); AluData = $urandom;
            exp_q.push_back({MemRd, MemData});
        end
        @(negedge Clk);
        idle_inputs();
        checks++;
        if (Occupancy !== 3'd3) begin
            failures++;
            $display("FAIL mid_queued: got occ=%0d, required 3", Occupancy);
        end
        #1 Reset_n = 1'b0;
        #1;
        checks++;
        if (RegWr !== 1'b0 || Occupancy !== 3'd0 || AluReady !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got regwr=%b occ=%0d ready=%b, required 0 0 0", RegWr, Occupancy, AluReady);
        end
        @(negedge Clk); @(negedge Clk);
        Reset_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge Clk);
            checks++;
            if (RegWr !== 1'b0 || Occupancy !== 3'd0) begin
                failures++;
                $display("FAIL post_reset_idle: got regwr=%b occ=%0d, required 0 0", RegWr, Occupancy);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            @(negedge Clk);
            AluValid = 1'($urandom_range(0, 1));
            AluRd    = 5'($urandom_range(0, 31));
            AluData  = $urandom;
            #1;
            checks++;
            if (AluReady !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready: got %b, required 1", AluReady);
            end
            if (AluValid && AluRd != 0) exp_q.push_back({AluRd, AluData});
        end
        @(negedge Clk);
        idle_inputs();
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_bypass();
        test_mem_priority();
        test_fill_backpressure();
        test_kill();
        test_zero_and_hazard();
        test_reset_mid();
        test_back_to_back();
        @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_writes: got %0d outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
